// File: rtl/display_serializer.sv
// Frame serializer for a shift-register display driver: snapshots a frame,
// clocks it out MSB first on SCLK/SDATA, then strobes SLATCH and reports DONE.
module display_serializer #(
    parameter int DisplayBufferSize = 256,
    parameter int ClkDiv            = 4
) (
    input  logic                         clk,
    input  logic                         RESET_N,
    input  logic [DisplayBufferSize-1:0] DisplayBuffer,
    input  logic                         START,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         SCLK,
    output logic                         SDATA,
    output logic                         SLATCH
);

    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int BitW = $clog2(DisplayBufferSize + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DisplayBufferSize - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                         state_reg, state_next;
    logic [DisplayBufferSize-1:0]   shift_reg, shift_next;
    logic [DivW-1:0]                div_reg, div_next;
    logic [BitW-1:0]                bit_reg, bit_next;
    logic                           busy_reg, busy_next;
    logic                           done_reg, done_next;
    logic                           sclk_reg, sclk_next;
    logic                           slatch_reg, slatch_next;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            div_reg    <= '0;
            bit_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sclk_reg   <= 1'b0;
            slatch_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            sclk_reg   <= sclk_next;
            slatch_reg <= slatch_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        sclk_next   = sclk_reg;
        slatch_next = slatch_reg;

        unique case (state_reg)
            IDLE: begin
                if (START) begin
                    state_next = SHIFT;
                    shift_next = DisplayBuffer;
                    div_next   = '0;
                    bit_next   = '0;
                    busy_next  = 1'b1;
                    sclk_next  = 1'b0;
                end
            end
            SHIFT: begin
                if (div_reg == DivLast) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    // Falling SCLK edge: advance to the next bit.
                    if (sclk_reg) begin
                        shift_next = {shift_reg[DisplayBufferSize-2:0], 1'b0};
                        bit_next   = bit_reg + 1'b1;
                        if (bit_reg == BitLast) begin
                            state_next  = LATCH;
                            slatch_next = 1'b1;
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            LATCH: begin
                if (div_reg == DivLast) begin
                    div_next    = '0;
                    state_next  = IDLE;
                    slatch_next = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                busy_next   = 1'b0;
                sclk_next   = 1'b0;
                slatch_next = 1'b0;
                shift_next  = '0;
            end
        endcase
    end

    // After a full frame every bit has been shifted out, so the MSB reads 0
    // in LATCH and IDLE without extra gating.
    assign SDATA  = shift_reg[DisplayBufferSize-1];
    assign BUSY   = busy_reg;
    assign DONE   = done_reg;
    assign SCLK   = sclk_reg;
    assign SLATCH = slatch_reg;

endmodule

// File: tb/tb_display_serializer.sv
// Directed bench for display_serializer: default 256-bit/ClkDiv=4 instance
// plus an 8-bit/ClkDiv=1 instance.
module tb_display_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] db = '0;
    logic         start = 1'b0;
    logic         busy, done, sclk, sdata, slatch;

    logic [7:0]   db_s = '0;
    logic         start_s = 1'b0;
    logic         busy_s, done_s, sclk_s, sdata_s, slatch_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_serializer dut (
        .clk(clk), .RESET_N(rst_n), .DisplayBuffer(db), .START(start),
        .BUSY(busy), .DONE(done), .SCLK(sclk), .SDATA(sdata), .SLATCH(slatch)
    );

    display_serializer #(.DisplayBufferSize(8), .ClkDiv(1)) dut_s (
        .clk(clk), .RESET_N(rst_n), .DisplayBuffer(db_s), .START(start_s),
        .BUSY(busy_s), .DONE(done_s), .SCLK(sclk_s), .SDATA(sdata_s), .SLATCH(slatch_s)
    );

    // Observes one frame of the default instance, starting at the first BUSY cycle.
    task automatic capture(input int max_cyc, output int busy_n, output int rise_n,
                           output int latch_n, output int done_n, output logic [255:0] bits,
                           output logic first_sd, output logic latch_bad, output logic timeout);
        logic prev_sclk;
        busy_n = 0; rise_n = 0; latch_n = 0; done_n = 0;
        bits = '0; latch_bad = 1'b0; timeout = 1'b1;
        first_sd = sdata;
        prev_sclk = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) done_n++;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            busy_n++;
            if (sclk && !prev_sclk) begin
                if (rise_n < 256) bits[255-rise_n] = sdata;
                rise_n++;
            end
            prev_sclk = sclk;
            if (slatch) begin
                latch_n++;
                if (sclk || sdata) latch_bad = 1'b1;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (done) done_n++;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, sclk, sdata, slatch} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000", {busy, done, sclk, sdata, slatch});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sclk, sdata, slatch, busy_s, done_s, sclk_s, sdata_s, slatch_s} !== 10'b0) begin
            errors++;
            $display("FAIL idle_outputs got %b want 0000000000",
                     {busy, done, sclk, sdata, slatch, busy_s, done_s, sclk_s, sdata_s, slatch_s});
        end
        $display("reset: idle outputs observed");
    endtask

    task automatic test_frame();
        int bn, rn, ln, dn;
        logic [255:0] bits, exp;
        logic fsd, lbad, to;
        exp = '0; exp[255] = 1'b1; exp[0] = 1'b1;
        db = exp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        capture(3000, bn, rn, ln, dn, bits, fsd, lbad, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL frame_timeout got %0b want 0", to); end
        checks++; if (fsd !== 1'b1) begin errors++; $display("FAIL frame_first_bit got %0b want 1", fsd); end
        checks++; if (bn != 2052) begin errors++; $display("FAIL frame_busy got %0d want 2052", bn); end
        checks++; if (rn != 256) begin errors++; $display("FAIL frame_sclk_rises got %0d want 256", rn); end
        checks++; if (bits !== exp) begin errors++; $display("FAIL frame_bits got %h want %h", bits, exp); end
        checks++; if (ln != 4) begin errors++; $display("FAIL frame_slatch got %0d want 4", ln); end
        checks++; if (lbad !== 1'b0) begin errors++; $display("FAIL frame_latch_lines got %0b want 0", lbad); end
        checks++; if (dn != 1) begin errors++; $display("FAIL frame_done got %0d want 1", dn); end
        $display("frame: busy=%0d rises=%0d slatch=%0d done=%0d", bn, rn, ln, dn);
    endtask

    task automatic test_snapshot();
        int bn, rn, ln, dn;
        logic [255:0] bits;
        logic fsd, lbad, to;
        db = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            capture(3000, bn, rn, ln, dn, bits, fsd, lbad, to);
            begin
                repeat (9) @(negedge clk);
                db = '1;
            end
        join
        checks++; if (bits !== 256'd0) begin errors++; $display("FAIL snapshot_bits got %h want 0", bits); end
        checks++; if (rn != 256) begin errors++; $display("FAIL snapshot_rises got %0d want 256", rn); end
        checks++; if (bn != 2052) begin errors++; $display("FAIL snapshot_busy got %0d want 2052", bn); end
        $display("snapshot: busy=%0d rises=%0d bits=%h", bn, rn, bits);
    endtask

    task automatic test_back_to_back();
        int d_idx[$];
        logic busy_at_done, busy_after_done;
        int k;
        db = {128{2'b01}};
        busy_at_done = 1'b1;
        busy_after_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                d_idx.push_back(i);
                if (d_idx.size() == 1) busy_at_done = busy;
            end
            if (d_idx.size() == 1 && d_idx[0] == i - 1) busy_after_done = busy;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (d_idx.size() != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", d_idx.size()); end
        if (d_idx.size() >= 2) begin
            checks++;
            if (d_idx[1] - d_idx[0] != 2053) begin
                errors++; $display("FAIL b2b_done_spacing got %0d want 2053", d_idx[1] - d_idx[0]);
            end
        end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got %0b want 0", busy_at_done); end
        checks++; if (busy_after_done !== 1'b1) begin errors++; $display("FAIL b2b_restart got %0b want 1", busy_after_done); end
        k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", busy); end
        @(negedge clk);
        $display("back_to_back: done_pulses=%0d", d_idx.size());
    endtask

    task automatic test_reset_abort();
        int bn, rn, ln, dn, seen_done;
        logic [255:0] bits;
        logic fsd, lbad, to;
        db = {64{4'hC}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1000) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %0b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sclk, sdata, slatch} !== 5'b0) begin
            errors++; $display("FAIL abort_async got %b want 00000", {busy, done, sclk, sdata, slatch});
        end
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen_done); end
        db = {128{2'b10}};
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        capture(3000, bn, rn, ln, dn, bits, fsd, lbad, to);
        checks++; if (bn != 2052) begin errors++; $display("FAIL abort_fresh_busy got %0d want 2052", bn); end
        checks++; if (bits !== {128{2'b10}}) begin errors++; $display("FAIL abort_fresh_bits got %h want %h", bits, {128{2'b10}}); end
        checks++; if (dn != 1) begin errors++; $display("FAIL abort_fresh_done got %0d want 1", dn); end
        $display("reset_abort: fresh frame busy=%0d done=%0d", bn, dn);
    endtask

    task automatic test_start_ignored();
        int bn, rn, ln, dn, extra;
        logic [255:0] bits;
        logic fsd, lbad, to;
        db = {32{8'h3C}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            capture(3000, bn, rn, ln, dn, bits, fsd, lbad, to);
            begin
                repeat (500) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (1549) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) extra++;
        end
        checks++; if (bn != 2052) begin errors++; $display("FAIL ignore_busy got %0d want 2052", bn); end
        checks++; if (bits !== {32{8'h3C}}) begin errors++; $display("FAIL ignore_bits got %h want %h", bits, {32{8'h3C}}); end
        checks++; if (ln != 4) begin errors++; $display("FAIL ignore_slatch got %0d want 4", ln); end
        checks++; if (extra != 0) begin errors++; $display("FAIL ignore_no_queue got %0d want 0", extra); end
        $display("start_ignored: busy=%0d slatch=%0d queued=%0d", bn, ln, extra);
    endtask

    task automatic test_small();
        int bn, ln, dn, rn, r0, r1;
        logic [7:0] bits;
        logic prev;
        bool_dummy: begin end
        bn = 0; ln = 0; dn = 0; rn = 0; r0 = -1; r1 = -1;
        bits = '0; prev = 1'b0;
        db_s = 8'hA5;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_s) dn++;
            if (!busy_s) break;
            bn++;
            if (sclk_s && !prev) begin
                if (rn < 8) bits[7-rn] = sdata_s;
                if (rn == 0) r0 = i;
                if (rn == 1) r1 = i;
                rn++;
            end
            prev = sclk_s;
            if (slatch_s) ln++;
            @(negedge clk);
        end
        @(negedge clk);
        if (done_s) dn++;
        checks++; if (bn != 17) begin errors++; $display("FAIL small_busy got %0d want 17", bn); end
        checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL small_bits got %h want a5", bits); end
        checks++; if (rn != 8) begin errors++; $display("FAIL small_rises got %0d want 8", rn); end
        checks++; if (r1 - r0 != 2) begin errors++; $display("FAIL small_sclk_period got %0d want 2", r1 - r0); end
        checks++; if (ln != 1) begin errors++; $display("FAIL small_slatch got %0d want 1", ln); end
        checks++; if (dn != 1) begin errors++; $display("FAIL small_done got %0d want 1", dn); end
        $display("small: busy=%0d bits=%h rises=%0d", bn, bits, rn);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_snapshot();
        test_back_to_back();
        test_reset_abort();
        test_start_ignored();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/display_serializer.md
DISPLAY_SERIALIZER -- requirements
Module: display_serializer

Interface
REQ-001 SHALL have parameter DisplayBufferSize, default 256, frame width in bits; legal values are even and ≥ 2.
REQ-002 SHALL have parameter ClkDiv, default 4, clk cycles per SCLK half-period; legal values are ≥ 1.
REQ-003 SHALL have port clk  input  1  global clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port DisplayBuffer  input  DisplayBufferSize  frame data driven by the Processor.
REQ-006 SHALL have port START  input  1  level-sampled frame request.
REQ-007 SHALL have port BUSY  output  1  high while a frame is in flight.
REQ-008 SHALL have port DONE  output  1  one-cycle frame-complete pulse.
REQ-009 SHALL have port SCLK  output  1  serial clock to the display driver.
REQ-010 SHALL have port SDATA  output  1  serial data, MSB first.
REQ-011 SHALL have port SLATCH  output  1  latch strobe; driver transfers its shift register to the panel.

Function
REQ-012 SHALL implement states IDLE, SHIFT, LATCH; all outputs registered.
REQ-013 IDLE: a rising clk edge with START=1 SHALL snapshot DisplayBuffer into the shift register, enter SHIFT, set BUSY=1, and clear the divider and bit counters.
REQ-014 Snapshot SHALL be the only DisplayBuffer sample per frame; later DisplayBuffer changes do not affect the frame.
REQ-015 SHIFT: SDATA SHALL equal shift-register MSB; the first bit appears in the same cycle BUSY rises.
REQ-016 SHIFT: the divider SHALL count 0..ClkDiv-1 and toggle SCLK on terminal count; SCLK starts at 0.
REQ-017 On each SCLK 1->0 toggle, the shift register SHALL shift left by one and the bit counter SHALL increment; SDATA is stable across every SCLK rising edge.
REQ-018 After the falling toggle that ends bit DisplayBufferSize-1, the block SHALL enter LATCH, with SCLK=0 and SDATA=0.
REQ-019 SHIFT duration SHALL be exactly DisplayBufferSize*2*ClkDiv cycles.
REQ-020 LATCH: SLATCH SHALL be 1 for exactly ClkDiv cycles, then the block SHALL return to IDLE.
REQ-021 IDLE entry from LATCH: in that same cycle, BUSY=0, SLATCH=0, and DONE=1 for exactly one cycle.
REQ-022 BUSY SHALL be high for exactly DisplayBufferSize*2*ClkDiv+ClkDiv cycles per frame (2052 at defaults).
REQ-023 START while BUSY=1 SHALL be ignored, with no queuing.
REQ-024 START held high SHALL begin a new frame on the cycle after DONE, giving back-to-back frames with one IDLE cycle between.
REQ-025 The bit counter SHALL be wide enough for DisplayBufferSize with no wrap within a frame.
REQ-026 IDLE outputs SHALL be SCLK=0, SDATA=0, SLATCH=0.

Reset
REQ-027 RESET_N=0 SHALL immediately, without waiting for clk, force IDLE, BUSY=0, DONE=0, SCLK=0, SDATA=0, SLATCH=0, and clear all counters and the shift register.
REQ-028 Reset mid-frame SHALL abort the frame with no DONE; after release, the first START SHALL begin a complete fresh frame.
REQ-029 START sampled on the first edge after RESET_N release SHALL be honoured.

Verification
REQ-030 Defaults, DisplayBuffer=256'h8000...0001, one-cycle START -> SDATA 1 for the first bit, 0 for bits 1..254, 1 for the last bit; 256 SCLK rises; SLATCH high 4 cycles; DONE 1 cycle; BUSY high 2052 cycles.
REQ-031 DisplayBuffer changed to all-ones 10 cycles after START, original frame all-zeros -> all 256 sampled bits are 0.
REQ-032 START held high for 5000 cycles -> two complete frames, DONE pulses 2053 cycles apart, one IDLE cycle between frames.
REQ-033 RESET_N pulsed low at cycle 1000 of a frame -> all outputs 0 asynchronously, no DONE; the next START yields a correct 2052-cycle frame.
REQ-034 ClkDiv=1, DisplayBufferSize=8, data 8'hA5 -> SCLK period 2 cycles, sampled bits 1,0,1,0,0,1,0,1, BUSY high 17 cycles.
REQ-035 START pulsed during SHIFT and during LATCH -> no effect on the frame or its timing.
